// File: rtl/bp_pkg.sv
// Types and constants shared by the branch resolve queue and the 2-bit predictor table.
package bp_pkg;

    localparam int PC_W    = 32;
    localparam int IDX_LSB = 2;
    localparam int IDX_MSB = 11;

    typedef struct packed {
        logic [PC_W-1:0] pc;
        logic            pred;
    } brq_rec_t;

    typedef enum logic {
        RUN   = 1'b0,
        DRAIN = 1'b1
    } brq_state_e;

endpackage

// File: rtl/brq_fifo.sv
// Generic DEPTH-entry circular buffer with push, pop, flush and a saturating occupancy count.
module brq_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 33
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       push_i,
    input  logic [WIDTH-1:0]           push_data_i,
    input  logic                       pop_i,
    input  logic                       flush_i,
    output logic [WIDTH-1:0]           head_o,
    output logic [$clog2(DEPTH+1)-1:0] count_o,
    output logic                       full_o,
    output logic                       empty_o
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH+1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             push_ok, pop_ok;

    assign full_o  = (count_q == CNT_W'(DEPTH));
    assign empty_o = (count_q == '0);
    assign push_ok = push_i & ~full_o & ~flush_i;
    assign pop_ok  = pop_i & ~empty_o;
    assign head_o  = mem_q[rd_ptr_q];
    assign count_o = count_q;

    always_comb begin
        // NOTE: every next-state value gets a default first so no latch is inferred.
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush_i) begin
            rd_ptr_d = wr_ptr_q;
            count_d  = '0;
        end else begin
            if (push_ok) wr_ptr_d = wr_ptr_q + PTR_W'(1);
            if (pop_ok)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
            case ({push_ok, pop_ok})
                2'b10:   count_d = count_q + CNT_W'(1);
                2'b01:   count_d = count_q - CNT_W'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments only.
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // NOTE: storage is not reset; occupancy alone decides which entries are meaningful.
    always_ff @(posedge clk) begin
        if (push_ok) mem_q[wr_ptr_q] <= push_data_i;
    end

endmodule

// File: rtl/branch_resolve_queue.sv
// In-order branch record queue between fetch and execute; issues predictor updates,
// flags mispredictions and ignores wrong-path traffic for a fixed drain window.
module branch_resolve_queue
    import bp_pkg::*;
#(
    parameter int DEPTH        = 4,
    parameter int DRAIN_CYCLES = 3
) (
    input  logic                       CLK,
    input  logic                       RESET,
    input  logic                       FetchBranch,
    input  logic [PC_W-1:0]            FetchPC,
    input  logic                       FetchPred,
    output logic                       Stall,
    input  logic                       ResolveValid,
    input  logic                       ResolveTaken,
    input  logic [PC_W-1:0]            ResolvePC,
    output logic                       UpdBranch,
    output logic                       UpdTaken,
    output logic [PC_W-1:0]            UpdPC,
    output logic                       Mispredict,
    output logic [$clog2(DEPTH+1)-1:0] Count,
    output logic                       Error
);

    localparam logic [3:0] DRAIN_LOAD = 4'(DRAIN_CYCLES);

    brq_state_e      state_q;
    logic [3:0]      drain_q;
    logic            upd_branch_q, upd_taken_q, mispredict_q;
    logic [PC_W-1:0] upd_pc_q;
    logic            error_q, error_d;

    brq_rec_t        head, push_rec;
    logic            full, empty;
    logic            run, pop_ok, mis_now, push_req;

    assign run      = (state_q == RUN);
    assign pop_ok   = run & ResolveValid & ~empty;
    assign mis_now  = pop_ok & (head.pred != ResolveTaken);
    // A mispredicting resolve squashes the queue, so a same-cycle push is wrong-path.
    assign push_req = run & FetchBranch & ~mis_now;
    assign push_rec = '{pc: FetchPC, pred: FetchPred};
    assign error_d  = error_q | (run & ResolveValid & (empty | (ResolvePC != head.pc)));

    brq_fifo #(
        .DEPTH (DEPTH),
        .WIDTH ($bits(brq_rec_t))
    ) u_fifo (
        .clk         (CLK),
        .rst_n       (RESET),
        .push_i      (push_req),
        .push_data_i (push_rec),
        .pop_i       (pop_ok),
        .flush_i     (mis_now),
        .head_o      (head),
        .count_o     (Count),
        .full_o      (full),
        .empty_o     (empty)
    );

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state_q      <= RUN;
            drain_q      <= '0;
            upd_branch_q <= 1'b0;
            upd_taken_q  <= 1'b0;
            upd_pc_q     <= '0;
            mispredict_q <= 1'b0;
            error_q      <= 1'b0;
        end else begin
            upd_branch_q <= pop_ok;
            upd_taken_q  <= pop_ok & ResolveTaken;
            upd_pc_q     <= pop_ok ? head.pc : '0;
            mispredict_q <= mis_now;
            error_q      <= error_d;
            case (state_q)
                RUN: begin
                    if (mis_now) begin
                        state_q <= DRAIN;
                        drain_q <= DRAIN_LOAD;
                    end
                end
                DRAIN: begin
                    drain_q <= drain_q - 4'd1;
                    if (drain_q == 4'd1) state_q <= RUN;
                end
            endcase
        end
    end

    assign Stall      = full;
    assign UpdBranch  = upd_branch_q;
    assign UpdTaken   = upd_taken_q;
    assign UpdPC      = upd_pc_q;
    assign Mispredict = mispredict_q;
    assign Error      = error_q;

endmodule

// File: tb/tb_branch_resolve_queue.sv
// Self-checking bench: directed scenarios plus random traffic against a queue-based model.
module tb_branch_resolve_queue;
    import bp_pkg::*;

    localparam int DEPTH        = 4;
    localparam int DRAIN_CYCLES = 3;
    localparam int CNT_W        = $clog2(DEPTH+1);

    logic             CLK = 1'b0;
    logic             RESET = 1'b0;
    logic             FetchBranch = 1'b0, FetchPred = 1'b0;
    logic             ResolveValid = 1'b0, ResolveTaken = 1'b0;
    logic [31:0]      FetchPC = '0, ResolvePC = '0;
    logic             Stall, UpdBranch, UpdTaken, Mispredict, Error;
    logic [31:0]      UpdPC;
    logic [CNT_W-1:0] Count;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 CLK = ~CLK;

    branch_resolve_queue #(
        .DEPTH        (DEPTH),
        .DRAIN_CYCLES (DRAIN_CYCLES)
    ) dut (
        .CLK          (CLK),
        .RESET        (RESET),
        .FetchBranch  (FetchBranch),
        .FetchPC      (FetchPC),
        .FetchPred    (FetchPred),
        .Stall        (Stall),
        .ResolveValid (ResolveValid),
        .ResolveTaken (ResolveTaken),
        .ResolvePC    (ResolvePC),
        .UpdBranch    (UpdBranch),
        .UpdTaken     (UpdTaken),
        .UpdPC        (UpdPC),
        .Mispredict   (Mispredict),
        .Count        (Count),
        .Error        (Error)
    );

    typedef struct {
        logic [31:0] pc;
        logic        pred;
    } rec_t;

    rec_t        mq[$];
    int          m_drain;
    bit          m_err;
    bit          e_upd, e_taken, e_mis;
    logic [31:0] e_pc;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_clear();
        mq.delete();
        m_drain = 0;
        m_err   = 1'b0;
        e_upd   = 1'b0;
        e_taken = 1'b0;
        e_mis   = 1'b0;
        e_pc    = '0;
    endtask

    // One clock edge of the reference behaviour, from the inputs sampled at that edge.
    task automatic model_edge(input bit fb, input logic [31:0] fpc, input bit fpred,
                              input bit rv, input bit rt, input logic [31:0] rpc);
        bit   full_before;
        rec_t h;
        e_upd   = 1'b0;
        e_taken = 1'b0;
        e_mis   = 1'b0;
        e_pc    = '0;
        if (m_drain > 0) begin
            m_drain--;
        end else begin
            full_before = (mq.size() == DEPTH);
            if (rv) begin
                if (mq.size() == 0) begin
                    m_err = 1'b1;
                end else begin
                    h       = mq.pop_front();
                    e_upd   = 1'b1;
                    e_taken = rt;
                    e_pc    = h.pc;
                    e_mis   = (h.pred != rt);
                    if (rpc != h.pc) m_err = 1'b1;
                end
            end
            if (e_mis) begin
                mq.delete();
                m_drain = DRAIN_CYCLES;
            end else if (fb && !full_before) begin
                mq.push_back('{pc: fpc, pred: fpred});
            end
        end
    endtask

    task automatic compare_all();
        check("count", 32'(Count), 32'(mq.size()));
        check("stall", 32'(Stall), 32'(mq.size() == DEPTH));
        check("upd_branch", 32'(UpdBranch), 32'(e_upd));
        check("mispredict", 32'(Mispredict), 32'(e_mis));
        check("error", 32'(Error), 32'(m_err));
        if (e_upd) begin
            check("upd_taken", 32'(UpdTaken), 32'(e_taken));
            check("upd_pc", UpdPC, e_pc);
            check("upd_idx", 32'(UpdPC[IDX_MSB:IDX_LSB]), 32'(e_pc[IDX_MSB:IDX_LSB]));
        end
    endtask

    // Called at a falling edge: drive, take one rising edge, then compare at the next falling edge.
    task automatic step(input bit fb, input logic [31:0] fpc, input bit fpred,
                        input bit rv, input bit rt, input logic [31:0] rpc);
        FetchBranch  = fb;
        FetchPC      = fpc;
        FetchPred    = fpred;
        ResolveValid = rv;
        ResolveTaken = rt;
        ResolvePC    = rpc;
        @(posedge CLK);
        model_edge(fb, fpc, fpred, rv, rt, rpc);
        @(negedge CLK);
        compare_all();
    endtask

    task automatic push(input logic [31:0] pc, input bit pred);
        step(1'b1, pc, pred, 1'b0, 1'b0, '0);
    endtask

    task automatic resolve(input logic [31:0] pc, input bit taken);
        step(1'b0, '0, 1'b0, 1'b1, taken, pc);
    endtask

    task automatic do_reset();
        FetchBranch  = 1'b0;
        ResolveValid = 1'b0;
        RESET        = 1'b0;
        #1;
        check("rst_upd_branch", 32'(UpdBranch), 32'd0);
        check("rst_upd_taken", 32'(UpdTaken), 32'd0);
        check("rst_upd_pc", UpdPC, 32'd0);
        check("rst_mispredict", 32'(Mispredict), 32'd0);
        check("rst_count", 32'(Count), 32'd0);
        check("rst_stall", 32'(Stall), 32'd0);
        check("rst_error", 32'(Error), 32'd0);
        model_clear();
        @(negedge CLK);
        RESET = 1'b1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not complete within time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [31:0] rnd_pc, rpc;
        bit          fb, rv, rt;

        @(negedge CLK);
        do_reset();

        // Single push/resolve round trip.
        push(32'h100, 1'b1);
        check("t1_count_after_push", 32'(Count), 32'd1);
        resolve(32'h100, 1'b1);
        check("t1_upd_branch", 32'(UpdBranch), 32'd1);
        check("t1_upd_taken", 32'(UpdTaken), 32'd1);
        check("t1_upd_pc", UpdPC, 32'h100);
        check("t1_mispredict", 32'(Mispredict), 32'd0);
        check("t1_count_after_pop", 32'(Count), 32'd0);

        // Fill to full, dropped push, concurrent push+pop at full, in-order drain.
        push(32'h10, 1'b0);
        push(32'h14, 1'b0);
        push(32'h18, 1'b0);
        push(32'h1C, 1'b0);
        check("t2_stall", 32'(Stall), 32'd1);
        check("t2_count", 32'(Count), 32'd4);
        push(32'h20, 1'b0);
        check("t2_count_after_drop", 32'(Count), 32'd4);
        step(1'b1, 32'h20, 1'b0, 1'b1, 1'b0, 32'h10);
        check("t3_upd_pc_10", UpdPC, 32'h10);
        check("t3_count_3", 32'(Count), 32'd3);
        step(1'b1, 32'h20, 1'b0, 1'b1, 1'b0, 32'h14);
        check("t3_upd_pc_14", UpdPC, 32'h14);
        check("t3_count_still_3", 32'(Count), 32'd3);
        resolve(32'h18, 1'b0);
        check("t2_upd_pc_18", UpdPC, 32'h18);
        resolve(32'h1C, 1'b0);
        check("t2_upd_pc_1c", UpdPC, 32'h1C);
        resolve(32'h20, 1'b0);
        check("t3_upd_pc_20", UpdPC, 32'h20);

        // Mispredict, drain window, recovery.
        push(32'h40, 1'b1);
        push(32'h44, 1'b0);
        resolve(32'h40, 1'b0);
        check("t4_mispredict", 32'(Mispredict), 32'd1);
        check("t4_upd_taken", 32'(UpdTaken), 32'd0);
        check("t4_count", 32'(Count), 32'd0);
        for (int i = 0; i < DRAIN_CYCLES; i++) begin
            step(1'b1, 32'h80, 1'b0, 1'b1, 1'b0, 32'h80);
            check("t4_drain_count", 32'(Count), 32'd0);
            check("t4_drain_no_upd", 32'(UpdBranch), 32'd0);
        end
        check("t4_drain_no_error", 32'(Error), 32'd0);
        push(32'h48, 1'b0);
        check("t4_push_after_drain", 32'(Count), 32'd1);
        resolve(32'h48, 1'b0);
        check("t4_upd_pc_48", UpdPC, 32'h48);

        // Resolve on empty queue; error is sticky.
        resolve(32'h0, 1'b1);
        check("t5_empty_no_upd", 32'(UpdBranch), 32'd0);
        check("t5_empty_error", 32'(Error), 32'd1);
        push(32'h50, 1'b1);
        resolve(32'h50, 1'b1);
        check("t5_error_sticky", 32'(Error), 32'd1);

        // PC mismatch: error, but update carries the head PC.
        @(negedge CLK);
        do_reset();
        push(32'h204, 1'b0);
        resolve(32'h200, 1'b0);
        check("t5_pc_error", 32'(Error), 32'd1);
        check("t5_pc_head", UpdPC, 32'h204);

        // Reset asserted while draining.
        do_reset();
        push(32'h300, 1'b1);
        push(32'h304, 1'b0);
        push(32'h308, 1'b0);
        check("t6_count_3", 32'(Count), 32'd3);
        resolve(32'h300, 1'b0);
        check("t6_mispredict", 32'(Mispredict), 32'd1);
        do_reset();
        push(32'h400, 1'b0);
        check("t6_push_after_reset", 32'(Count), 32'd1);

        // Random traffic, with periodic resets to re-arm the sticky error.
        for (int seg = 0; seg < 6; seg++) begin
            do_reset();
            for (int c = 0; c < 300; c++) begin
                fb     = ($urandom % 3) != 0;
                rnd_pc = {$urandom_range(32'h3FFF_FFFF, 0), 2'b00};
                rv     = ($urandom % 2) != 0;
                if (mq.size() > 0 && m_drain == 0) begin
                    rt  = (($urandom % 6) == 0) ? ~mq[0].pred : mq[0].pred;
                    rpc = (($urandom % 25) == 0) ? rnd_pc ^ 32'h4 : mq[0].pc;
                end else begin
                    rt  = $urandom % 2;
                    rpc = $urandom;
                end
                step(fb, rnd_pc, 1'($urandom % 2), rv, rt, rpc);
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
